// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the pointer and synchroniser blocks.
// Functions work on 16-bit operands; callers zero-extend narrower pointers.
package gray_pkg;

    localparam int GRAY_SYNC_MIN = 2;
    localparam int GRAY_MAX_W    = 16;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic multi_bit_change(input logic [GRAY_MAX_W-1:0] a,
                                              input logic [GRAY_MAX_W-1:0] b);
        return $countones(a ^ b) > 1;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for an incoming Gray pointer, plus a one-cycle
// history copy of the chain output used for step checking.
module gray_sync
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] hist_o
);

    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  hist_q;
    logic [WIDTH-1:0]                  hist_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = gray_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign hist_o = hist_q;

endmodule

// File: rtl/gray_ptr.sv
// Local up/down pointer with registered Gray export, synchronised remote
// pointer decode, local-minus-remote distance and remote Gray-step checker.
module gray_ptr
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] ptr_bin,
    output logic [WIDTH-1:0] ptr_gray,
    input  logic [WIDTH-1:0] rmt_gray_i,
    output logic [WIDTH-1:0] rmt_bin,
    output logic             rmt_vld,
    output logic [WIDTH-1:0] diff,
    output logic             gray_err
);

    localparam int STAGES    = (SYNC_STAGES < GRAY_SYNC_MIN) ? GRAY_SYNC_MIN : SYNC_STAGES;
    localparam int VLD_EDGES = STAGES + 1;
    localparam logic [WIDTH-1:0] PTR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ptr_bin_q,  ptr_bin_d;
    logic [WIDTH-1:0] ptr_gray_q, ptr_gray_d;
    logic [WIDTH-1:0] rmt_bin_q,  rmt_bin_d;
    logic [2:0]       vld_cnt_q,  vld_cnt_d;
    logic             vld_q,      vld_d;
    logic             gray_err_q, gray_err_d;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] sync_hist;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .gray_i (rmt_gray_i),
        .sync_o (sync_out),
        .hist_o (sync_hist)
    );

    always_comb begin
        ptr_bin_d = ptr_bin_q;
        if (clr) begin
            ptr_bin_d = '0;
        end else if (inc) begin
            ptr_bin_d = dir ? (ptr_bin_q - PTR_ONE) : (ptr_bin_q + PTR_ONE);
        end
        // Gray is taken from the next binary value so both copies land on one edge.
        ptr_gray_d = WIDTH'(bin2gray(16'(ptr_bin_d)));
    end

    always_comb begin
        rmt_bin_d = WIDTH'(gray2bin(16'(sync_out)));
        vld_cnt_d = (vld_cnt_q != 3'd0) ? (vld_cnt_q - 3'd1) : 3'd0;
        vld_d     = vld_q | (vld_cnt_q == 3'd1);
        // Gated by the already-valid flag so the flush from reset never flags.
        gray_err_d = vld_q & multi_bit_change(16'(sync_out), 16'(sync_hist));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            rmt_bin_q  <= '0;
            vld_cnt_q  <= 3'(VLD_EDGES);
            vld_q      <= 1'b0;
            gray_err_q <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            rmt_bin_q  <= rmt_bin_d;
            vld_cnt_q  <= vld_cnt_d;
            vld_q      <= vld_d;
            gray_err_q <= gray_err_d;
        end
    end

    assign ptr_bin  = ptr_bin_q;
    assign ptr_gray = ptr_gray_q;
    assign rmt_bin  = rmt_bin_q;
    assign rmt_vld  = vld_q;
    assign gray_err = gray_err_q;
    assign diff     = ptr_bin_q - rmt_bin_q;

endmodule
